stream_req_arbiter: RTL and testbench

Shares the single compressed-data stream port (input activations / filter weights) among NUM_PE PE controllers.
- Each PE controller raises a stream request: kind, channel and compressed length.
- The arbiter grants requests round-robin and drives a valid/ready beat stream tagged with PE id, kind and channel.
- It pulses a per-PE done when the burst completes; that pulse feeds the PE controller's Stream_input_finish_PE / Stream_filter_finish inputs.

---
 rtl/stream_req_arbiter.sv | 168 ++++++++++++++++
 tb/tb_stream_req_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_req_arbiter.sv
// Round-robin arbiter sharing one compressed-data stream port among NUM_PE PE controllers.
// Optional build macro FILTER_PRIORITY_EN: filter requests win over input requests in arbitration.
module stream_req_arbiter #(
  parameter int NUM_PE = 8,
  parameter int LEN_W  = 10,
  parameter int CH_W   = 3,
  localparam int PE_W  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_PE-1:0]       req_valid,
  input  logic [NUM_PE-1:0]       req_is_filter,
  input  logic [NUM_PE*CH_W-1:0]  req_channel,
  input  logic [NUM_PE*LEN_W-1:0] req_len,
  output logic [NUM_PE-1:0]       req_grant,
  output logic                    strm_valid,
  input  logic                    strm_ready,
  output logic [PE_W-1:0]         strm_pe_id,
  output logic                    strm_is_filter,
  output logic [CH_W-1:0]         strm_channel,
  output logic                    strm_last,
  output logic [NUM_PE-1:0]       stream_done,
  output logic                    busy,
  output logic [1:0]              dbg_state
);

  // Handshake: a beat transfers on a rising edge where strm_valid && strm_ready;
  // strm_valid never drops and the tags never change until that beat is taken.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PE_W-1:0]   r_rr_ptr;
  logic [PE_W-1:0]   r_pe_id;
  logic              r_is_filter;
  logic [CH_W-1:0]   r_channel;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_beat_cnt;
  logic [NUM_PE-1:0] r_grant;

  logic [NUM_PE-1:0] w_cand;
  logic              w_found;
  logic [PE_W-1:0]   w_winner;
  logic [PE_W-1:0]   w_idx;
  logic [PE_W-1:0]   w_rr_nxt;
  logic [NUM_PE-1:0] w_win_oh;
  logic [CH_W-1:0]   w_ch_a  [NUM_PE];
  logic [LEN_W-1:0]  w_len_a [NUM_PE];
  logic              w_last;
  logic              w_take;

  always_comb begin
    for (int g = 0; g < NUM_PE; g++) begin
      w_ch_a[g]  = req_channel[g*CH_W +: CH_W];
      w_len_a[g] = req_len[g*LEN_W +: LEN_W];
    end
  end

`ifdef FILTER_PRIORITY_EN
  logic w_any_filter;
  always_comb begin
    w_any_filter = |(req_valid & req_is_filter);
    w_cand       = w_any_filter ? (req_valid & req_is_filter)
                                : (req_valid & ~req_is_filter);
  end
`else
  always_comb begin
    w_cand = req_valid;
  end
`endif

  // Scan rr_ptr, rr_ptr+1, ... (mod NUM_PE); the first candidate wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      w_idx = PE_W'((int'(r_rr_ptr) + i) % NUM_PE);
      if (!w_found && w_cand[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_comb begin
    w_rr_nxt = (w_winner == PE_W'(NUM_PE - 1)) ? '0 : w_winner + 1'b1;
    w_win_oh = '0;
    w_win_oh[w_winner] = 1'b1;
  end

  assign w_last = (r_state == S_STREAM) && (r_beat_cnt == r_len - LEN_W'(1));
  assign w_take = (r_state == S_STREAM) && strm_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = (w_len_a[w_winner] == '0) ? S_DONE : S_STREAM;
        end
      end
      S_STREAM: begin
        if (w_take && w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_pe_id     <= '0;
      r_is_filter <= 1'b0;
      r_channel   <= '0;
      r_len       <= '0;
      r_beat_cnt  <= '0;
      r_grant     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_pe_id     <= w_winner;
            r_is_filter <= req_is_filter[w_winner];
            r_channel   <= w_ch_a[w_winner];
            r_len       <= w_len_a[w_winner];
            r_grant     <= w_win_oh;
            r_rr_ptr    <= w_rr_nxt;
          end
        end
        S_STREAM: begin
          if (w_take) begin
            r_beat_cnt <= r_beat_cnt + LEN_W'(1);
          end
        end
        default: r_beat_cnt <= '0;
      endcase
    end
  end

  always_comb begin
    stream_done = '0;
    if (r_state == S_DONE) begin
      stream_done[r_pe_id] = 1'b1;
    end
  end

  assign req_grant      = r_grant;
  assign strm_valid     = (r_state == S_STREAM);
  assign strm_last      = w_last;
  assign strm_pe_id     = r_pe_id;
  assign strm_is_filter = r_is_filter;
  assign strm_channel   = r_channel;
  assign busy           = (r_state != S_IDLE);
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_stream_req_arbiter.sv
// Directed bench for stream_req_arbiter: expected grant/beat/done events are queued at issue time
// and a monitor pops and compares them as the DUT produces them.
`timescale 1ns/100ps
module tb_stream_req_arbiter;
  localparam int NUM_PE = 8;
  localparam int LEN_W  = 10;
  localparam int CH_W   = 3;
  localparam int W      = 10;

  logic                    clk;
  logic                    rst;
  logic [NUM_PE-1:0]       req_valid;
  logic [NUM_PE-1:0]       req_is_filter;
  logic [NUM_PE*CH_W-1:0]  req_channel;
  logic [NUM_PE*LEN_W-1:0] req_len;
  logic [NUM_PE-1:0]       req_grant;
  logic                    strm_valid;
  logic                    strm_ready;
  logic [2:0]              strm_pe_id;
  logic                    strm_is_filter;
  logic [CH_W-1:0]         strm_channel;
  logic                    strm_last;
  logic [NUM_PE-1:0]       stream_done;
  logic                    busy;
  logic [1:0]              dbg_state;

  stream_req_arbiter #(.NUM_PE(NUM_PE), .LEN_W(LEN_W), .CH_W(CH_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_is_filter(req_is_filter),
    .req_channel(req_channel), .req_len(req_len),
    .req_grant(req_grant),
    .strm_valid(strm_valid), .strm_ready(strm_ready),
    .strm_pe_id(strm_pe_id), .strm_is_filter(strm_is_filter),
    .strm_channel(strm_channel), .strm_last(strm_last),
    .stream_done(stream_done), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic         ready_pat[$];
  int           grant_cyc_q[$];
  int           grant_pe_q[$];
  int           checks = 0;
  int           errors = 0;
  int           beats_seen = 0;
  bit           any_valid = 0;

  // item = {kind[1:0], pe[2:0], ch[2:0], filter, last}; kind 0 grant, 1 beat, 2 done
  function automatic logic [W-1:0] mk(input logic [1:0] k, input logic [2:0] pe,
                                      input logic [2:0] ch, input logic f, input logic l);
    return {k, pe, ch, f, l};
  endfunction

  function automatic logic [2:0] oh2idx(input logic [NUM_PE-1:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < NUM_PE; i++) if (v[i]) r = 3'(i);
    return r;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pop_cmp(input string name, input logic [W-1:0] act);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: unexpected event %0h, nothing expected (cycle %0d)", name, act, cyc);
    end else begin
      cmp(name, 32'(act), 32'(exp_q.pop_front()));
    end
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    logic [W-1:0] front;
    #1;
    if (!rst) begin
      if (req_grant != '0) begin
        cmp("grant_onehot", 32'($onehot(req_grant)), 32'd1);
        pop_cmp("grant", mk(2'd0, oh2idx(req_grant), 3'd0, 1'b0, 1'b0));
        grant_cyc_q.push_back(cyc);
        grant_pe_q.push_back(int'(oh2idx(req_grant)));
      end
      if (strm_valid) begin
        any_valid = 1;
        cmp("busy_in_stream", 32'(busy), 32'd1);
        if (exp_q.size() != 0) begin
          front = exp_q[0];
          if (front[9:8] == 2'd1)
            cmp("tags_stable", {strm_pe_id, strm_channel, strm_is_filter},
                {front[7:5], front[4:2], front[1]});
        end
        if (strm_ready) begin
          pop_cmp("beat", mk(2'd1, strm_pe_id, strm_channel, strm_is_filter, strm_last));
          beats_seen++;
        end
      end
      if (stream_done != '0) begin
        cmp("done_onehot", 32'($onehot(stream_done)), 32'd1);
        pop_cmp("done", mk(2'd2, oh2idx(stream_done), 3'd0, 1'b0, 1'b0));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    req_valid = req_valid & ~req_grant;
    if (ready_pat.size() != 0) strm_ready = ready_pat.pop_front();
    else strm_ready = 1'b1;
  endtask

  task automatic issue(input int pe, input logic f, input logic [2:0] ch, input int len);
    req_is_filter[pe] = f;
    req_channel[pe*CH_W +: CH_W] = ch;
    req_len[pe*LEN_W +: LEN_W] = LEN_W'(len);
    req_valid[pe] = 1'b1;
    exp_q.push_back(mk(2'd0, 3'(pe), 3'd0, 1'b0, 1'b0));
    for (int b = 0; b < len; b++)
      exp_q.push_back(mk(2'd1, 3'(pe), ch, f, (b == len - 1)));
    exp_q.push_back(mk(2'd2, 3'(pe), 3'd0, 1'b0, 1'b0));
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || req_valid != '0) && n < budget) begin
      tick();
      n++;
    end
    cmp("drained_queue", 32'(exp_q.size()), 32'd0);
    cmp("idle_after", 32'(busy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    cmp({tag, "_grant"}, 32'(req_grant), 32'd0);
    cmp({tag, "_valid"}, 32'(strm_valid), 32'd0);
    cmp({tag, "_last"}, 32'(strm_last), 32'd0);
    cmp({tag, "_done"}, 32'(stream_done), 32'd0);
    cmp({tag, "_busy"}, 32'(busy), 32'd0);
    cmp({tag, "_tags"}, {strm_pe_id, strm_channel, strm_is_filter}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    ready_pat.delete();
    req_valid = '0;
    strm_ready = 1'b1;
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    int issue_cyc;
    int b0;
    int n;
    rst = 1'b1;
    req_valid = '0;
    req_is_filter = '0;
    req_channel = '0;
    req_len = '0;
    strm_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    tick();

    // single input burst, len 4, channel 2
    grant_cyc_q.delete();
    issue_cyc = cyc;
    issue(0, 1'b0, 3'd2, 4);
    wait_drain(100);
    cmp("t1_grants", 32'(grant_cyc_q.size()), 32'd1);
    if (grant_cyc_q.size() != 0) cmp("t1_latency", 32'(grant_cyc_q[0]), 32'(issue_cyc + 1));

    // PE2 and PE5 together: PE2 first, 2-cycle gap between bursts
    grant_cyc_q.delete();
    issue(2, 1'b0, 3'd3, 3);
    issue(5, 1'b1, 3'd4, 3);
    wait_drain(100);
    cmp("t2_grants", 32'(grant_cyc_q.size()), 32'd2);
    if (grant_cyc_q.size() == 2)
      cmp("t2_grant_spacing", 32'(grant_cyc_q[1] - grant_cyc_q[0]), 32'd5);

    // rr_ptr now 6: PE7 must beat PE1
    issue(7, 1'b1, 3'd4, 2);
    issue(1, 1'b0, 3'd6, 1);
    wait_drain(100);

    // back-pressure: ready 1,0,0,1,1,0,1,1 over a 5-beat burst
    b0 = beats_seen;
    issue(0, 1'b1, 3'd7, 5);
    ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    wait_drain(100);
    cmp("t3_beats", 32'(beats_seen - b0), 32'd5);

    // zero-length request
    any_valid = 0;
    issue(3, 1'b1, 3'd1, 0);
    wait_drain(100);
    cmp("t4_no_valid", 32'(any_valid), 32'd0);

    // reset mid-burst after two accepted beats
    b0 = beats_seen;
    issue(4, 1'b0, 3'd5, 8);
    n = 0;
    while (beats_seen < b0 + 2 && n < 50) begin
      tick();
      n++;
    end
    cmp("t5_reach_two_beats", 32'(beats_seen - b0), 32'd2);
    @(posedge clk);
    #0.5 rst = 1'b1;
    #0.2;
    check_all_zero("midrst");
    cmp("t5_pending_at_reset", 32'(exp_q.size()), 32'd7);
    do_reset();
    tick();
    b0 = beats_seen;
    issue(4, 1'b0, 3'd5, 8);
    wait_drain(100);
    cmp("t5_full_rerun", 32'(beats_seen - b0), 32'd8);

    // PE1 input vs PE6 filter from rr_ptr 0
    do_reset();
    tick();
    grant_pe_q.delete();
`ifdef FILTER_PRIORITY_EN
    issue(6, 1'b1, 3'd2, 2);
    issue(1, 1'b0, 3'd3, 2);
    wait_drain(100);
    if (grant_pe_q.size() != 0) cmp("t6_first_grant", 32'(grant_pe_q[0]), 32'd6);
`else
    issue(1, 1'b0, 3'd3, 2);
    issue(6, 1'b1, 3'd2, 2);
    wait_drain(100);
    if (grant_pe_q.size() != 0) cmp("t6_first_grant", 32'(grant_pe_q[0]), 32'd1);
`endif
    cmp("t6_grants", 32'(grant_pe_q.size()), 32'd2);

    repeat (3) tick();
    cmp("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
